// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: parses "Raaaa<CR>" / "Waaaadd<CR>" ASCII lines into a bus request on a valid/ack handshake.
// Rev 1.0 -- define HEX_CMD_LOWERCASE_EN to also accept 'w', 'r' and 'a'-'f'.
`default_nettype none

module hex_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic        cmd_write,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        err,
  output logic        overrun
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_EOL  = 3'd3,
    S_PEND = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            write_q, write_d;
  logic [1:0]      nib_q, nib_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            ovr_q, ovr_d;

  logic [4:0]      hex;
  logic            is_w, is_r, counting;

  // {valid, nibble}
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= "0" && b <= "9")      r = {1'b1, 4'(b - 8'h30)};
    else if (b >= "A" && b <= "F") r = {1'b1, 4'(b - 8'h37)};
`ifdef HEX_CMD_LOWERCASE_EN
    else if (b >= "a" && b <= "f") r = {1'b1, 4'(b - 8'h57)};
`endif
    return r;
  endfunction

  assign hex = hex_decode(rx_data);
`ifdef HEX_CMD_LOWERCASE_EN
  assign is_w = (rx_data == "W") || (rx_data == "w");
  assign is_r = (rx_data == "R") || (rx_data == "r");
`else
  assign is_w = (rx_data == "W");
  assign is_r = (rx_data == "R");
`endif
  assign counting = (state_q == S_ADDR) || (state_q == S_DATA) ||
                    (state_q == S_EOL)  || (state_q == S_ERR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = write_q;
    nib_d   = nib_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;

    if (state_q == S_PEND) begin
      tmo_d = '0;
      if (cmd_ack) state_d = S_IDLE;
      if (new_rx_data) ovr_d = 1'b1;
    end else if (new_rx_data) begin
      tmo_d = '0;
      if (rx_data != CH_SP && rx_data != CH_LF) begin
        unique case (state_q)
          S_IDLE: begin
            if (is_w || is_r) begin
              addr_d  = '0;
              data_d  = '0;
              write_d = is_w;
              nib_d   = '0;
              state_d = S_ADDR;
            end else if (rx_data != CH_CR) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
          S_ADDR: begin
            if (hex[4]) begin
              addr_d = {addr_q[11:0], hex[3:0]};
              nib_d  = nib_q + 2'd1;
              if (nib_q == 2'd3) begin
                nib_d   = '0;
                state_d = write_q ? S_DATA : S_EOL;
              end
            end else begin
              err_d   = 1'b1;
              state_d = (rx_data == CH_CR) ? S_IDLE : S_ERR;
            end
          end
          S_DATA: begin
            if (hex[4]) begin
              data_d = {data_q[3:0], hex[3:0]};
              nib_d  = nib_q + 2'd1;
              if (nib_q == 2'd1) begin
                nib_d   = '0;
                state_d = S_EOL;
              end
            end else begin
              err_d   = 1'b1;
              state_d = (rx_data == CH_CR) ? S_IDLE : S_ERR;
            end
          end
          S_EOL: begin
            if (rx_data == CH_CR) begin
              state_d = S_PEND;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
          S_ERR: begin
            if (rx_data == CH_CR) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end else if (TIMEOUT_CYCLES > 0 && counting) begin
      if (tmo_q == TLAST) begin
        tmo_d   = '0;
        nib_d   = '0;
        err_d   = (state_q != S_ERR);
        state_d = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    valid_d = (state_d == S_PEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      nib_q   <= '0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      nib_q   <= nib_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_write = write_q;
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign err       = err_q;
  assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_cmd_parser.sv
// tb_hex_cmd_parser: table-driven command lines plus hand-written handshake, overrun, reset and timeout sequences.
`default_nettype none

module tb_hex_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        new_rx_data = 1'b0;
  logic        cmd_valid;
  logic        cmd_ack = 1'b0;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        err;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;

  hex_cmd_parser #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .new_rx_data (new_rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_ack     (cmd_ack),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .err         (err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (err) err_cnt++;
    if (overrun) ovr_cnt++;
  end

  typedef struct {
    string       line;
    bit          v;
    bit          w;
    logic [15:0] a;
    logic [7:0]  d;
    int          e;
    int          o;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_line(input string s);
    for (int k = 0; k < s.len(); k++) send_byte(s[k]);
  endtask

  task automatic do_ack(input string name);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    check({name, " valid after ack"}, {31'd0, cmd_valid}, 32'd0);
  endtask

  initial begin
    int e0, o0;

    vecs.push_back('{"W1234AB\015",      1'b1, 1'b1, 16'h1234, 8'hAB, 0, 0});
    vecs.push_back('{"R FFFE\015\012",   1'b1, 1'b0, 16'hFFFE, 8'h00, 0, 1});
    vecs.push_back('{"W12G4\015",        1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
    vecs.push_back('{"R0000\015",        1'b1, 1'b0, 16'h0000, 8'h00, 0, 0});
    vecs.push_back('{"R12\015",          1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
    vecs.push_back('{"\015",             1'b0, 1'b0, 16'h0000, 8'h00, 0, 0});
    vecs.push_back('{"RABCDE\015",       1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
    vecs.push_back('{"WFFFF00\015",      1'b1, 1'b1, 16'hFFFF, 8'h00, 0, 0});
    vecs.push_back('{"XQ\015",           1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
    vecs.push_back('{"W0000\015",        1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
`ifdef HEX_CMD_LOWERCASE_EN
    vecs.push_back('{"w1234AB\015",      1'b1, 1'b1, 16'h1234, 8'hAB, 0, 0});
    vecs.push_back('{"W00ffab\015",      1'b1, 1'b1, 16'h00FF, 8'hAB, 0, 0});
`else
    vecs.push_back('{"w1234AB\015",      1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
    vecs.push_back('{"W00ffab\015",      1'b0, 1'b0, 16'h0000, 8'h00, 1, 0});
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst valid", {31'd0, cmd_valid}, 32'd0);
    check("rst write", {31'd0, cmd_write}, 32'd0);
    check("rst addr",  {16'd0, cmd_addr}, 32'd0);
    check("rst data",  {24'd0, cmd_data}, 32'd0);
    check("rst err",   {31'd0, err}, 32'd0);
    check("rst ovr",   {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      e0 = err_cnt;
      o0 = ovr_cnt;
      send_line(vecs[i].line);
      @(negedge clk);
      check($sformatf("v%0d valid", i), {31'd0, cmd_valid}, {31'd0, vecs[i].v});
      if (vecs[i].v) begin
        check($sformatf("v%0d write", i), {31'd0, cmd_write}, {31'd0, vecs[i].w});
        check($sformatf("v%0d addr", i), {16'd0, cmd_addr}, {16'd0, vecs[i].a});
        check($sformatf("v%0d data", i), {24'd0, cmd_data}, {24'd0, vecs[i].d});
        do_ack($sformatf("v%0d", i));
      end
      @(negedge clk);
      check($sformatf("v%0d err pulses", i), err_cnt - e0, vecs[i].e);
      check($sformatf("v%0d ovr pulses", i), ovr_cnt - o0, vecs[i].o);
    end

    // valid one cycle after CR, held until ack on its 3rd cycle
    send_byte("W"); send_byte("1"); send_byte("2"); send_byte("3");
    send_byte("4"); send_byte("A"); send_byte("B");
    rx_data = 8'h0D;
    new_rx_data = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    check("hs valid c1", {31'd0, cmd_valid}, 32'd1);
    @(negedge clk);
    check("hs valid c2", {31'd0, cmd_valid}, 32'd1);
    @(negedge clk);
    check("hs valid c3", {31'd0, cmd_valid}, 32'd1);
    do_ack("hs");
    @(negedge clk);

    // overrun while pending, then byte together with ack
    send_line("W5678CD\015");
    e0 = err_cnt;
    o0 = ovr_cnt;
    send_byte("R");
    check("ovr pulses", ovr_cnt - o0, 1);
    check("ovr err", err_cnt - e0, 0);
    check("ovr valid", {31'd0, cmd_valid}, 32'd1);
    check("ovr addr", {16'd0, cmd_addr}, 32'h5678);
    check("ovr data", {24'd0, cmd_data}, 32'hCD);
    rx_data = "W";
    new_rx_data = 1'b1;
    cmd_ack = 1'b1;
    @(negedge clk);
    new_rx_data = 1'b0;
    cmd_ack = 1'b0;
    check("ack+byte valid", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);
    check("ack+byte ovr", ovr_cnt - o0, 2);
    send_line("R0001\015");
    @(negedge clk);
    check("post-ovr valid", {31'd0, cmd_valid}, 32'd1);
    check("post-ovr addr", {16'd0, cmd_addr}, 32'h0001);
    do_ack("post-ovr");

    // reset mid-command and while pending
    send_line("W12");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst addr", {16'd0, cmd_addr}, 32'd0);
    e0 = err_cnt;
    send_line("34AB\015");
    @(negedge clk);
    check("midrst err", err_cnt - e0, 1);
    check("midrst valid", {31'd0, cmd_valid}, 32'd0);
    send_line("R1111\015");
    check("pendrst valid pre", {31'd0, cmd_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("pendrst valid", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);

    // timeout after 8 idle cycles inside a command
    send_byte("W");
    send_byte("1");
    e0 = err_cnt;
    repeat (5) @(negedge clk);
    check("tmo early", err_cnt - e0, 0);
    repeat (4) @(negedge clk);
    check("tmo err", err_cnt - e0, 1);
    e0 = err_cnt;
    send_line("AB\015");
    @(negedge clk);
    check("tmo after err", err_cnt - e0, 1);
    check("tmo after valid", {31'd0, cmd_valid}, 32'd0);

    // no err from a timeout that expires in the error state
    send_byte("Z");
    e0 = err_cnt;
    repeat (12) @(negedge clk);
    check("tmo in err", err_cnt - e0, 0);
    send_line("R00A5\015");
    @(negedge clk);
    check("tmo recover valid", {31'd0, cmd_valid}, 32'd1);
    check("tmo recover addr", {16'd0, cmd_addr}, 32'h00A5);
    do_ack("tmo recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
